// File: rtl/ps2_key_event_ctrl_pkg.sv
// Shared scan-code, key-id, FSM-state and event-width definitions for the PS/2 key event path.
package ps2_key_defs;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ONE   = 8'h16;
    localparam logic [7:0] SC_TWO   = 8'h1E;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [1:0] KEY_SPACE = 2'd0;
    localparam logic [1:0] KEY_ENTER = 2'd1;
    localparam logic [1:0] KEY_ONE   = 2'd2;
    localparam logic [1:0] KEY_TWO   = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam int EVT_W = 3;

    typedef struct packed {
        logic       hit;
        logic [1:0] id;
    } key_lookup_t;

    function automatic key_lookup_t lookup_key(input logic [7:0] code);
        key_lookup_t r;
        r = '0;
        case (code)
            SC_SPACE: r = '{hit: 1'b1, id: KEY_SPACE};
            SC_ENTER: r = '{hit: 1'b1, id: KEY_ENTER};
            SC_ONE:   r = '{hit: 1'b1, id: KEY_ONE};
            SC_TWO:   r = '{hit: 1'b1, id: KEY_TWO};
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_event_ctrl_if.sv
// Byte-in / event-out bus of the PS/2 key event controller.
interface ps2_key_event_ctrl_if
    import ps2_key_defs::*;
    ;
    logic [7:0]       rx_data;
    logic             rx_strobe;
    logic             evt_valid;
    logic [EVT_W-1:0] evt_data;
    logic             evt_ready;

    modport master (output rx_data, output rx_strobe, output evt_ready,
                    input  evt_valid, input evt_data);
    modport slave  (input  rx_data, input rx_strobe, input evt_ready,
                    output evt_valid, output evt_data);
endinterface

// File: rtl/ps2_key_event_ctrl_key_evt_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only if a pop happens in the same cycle.
module key_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code decoder: prefix FSM, per-key level state, typematic suppression, event FIFO.
// Optional build macro KEY_EVT_RELEASE_EN enables pushing release events.
module ps2_key_event_ctrl
    import ps2_key_defs::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    ps2_key_event_ctrl_if.slave  bus,
    output logic [3:0]           key_held,
    output logic                 overflow,
    input  logic                 clr_overflow
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    tmo_q, tmo_d;
    logic [3:0]       held_q, held_d;
    logic             ovf_q, ovf_d;
    logic             push;
    logic [EVT_W-1:0] push_data;
    logic             pop, fifo_full, fifo_empty;
    logic [EVT_W-1:0] fifo_rdata;
    key_lookup_t      kl;

    assign kl = lookup_key(bus.rx_data);

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        held_d    = held_q;
        push      = 1'b0;
        push_data = '0;
        if (bus.rx_strobe) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data == SC_BREAK)    state_d = ST_BRK;
                    else if (bus.rx_data == SC_EXT) state_d = ST_EXT;
                    else if (kl.hit && !held_q[kl.id]) begin
                        held_d[kl.id] = 1'b1;
                        push          = 1'b1;
                        push_data     = {1'b0, kl.id};
                    end
                end
                ST_BRK: begin
                    if (bus.rx_data == SC_BREAK)    state_d = ST_BRK;
                    else if (bus.rx_data == SC_EXT) state_d = ST_EXT_BRK;
                    else begin
                        state_d = ST_IDLE;
                        if (kl.hit && held_q[kl.id]) begin
                            held_d[kl.id] = 1'b0;
`ifdef KEY_EVT_RELEASE_EN
                            push      = 1'b1;
                            push_data = {1'b1, kl.id};
`endif
                        end
                    end
                end
                ST_EXT: begin
                    if (bus.rx_data == SC_BREAK)    state_d = ST_EXT_BRK;
                    else if (bus.rx_data != SC_EXT) state_d = ST_IDLE;
                end
                default: begin
                    if (bus.rx_data != SC_BREAK && bus.rx_data != SC_EXT) state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            // the idle cycle that would bring the count to TIMEOUT_CYCLES abandons the prefix
            if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign pop = bus.evt_valid & bus.evt_ready;

    always_comb begin
        ovf_d = ovf_q;
        if (clr_overflow) ovf_d = 1'b0;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            held_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
        end
    end

    key_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.evt_valid = ~fifo_empty;
`ifdef KEY_EVT_RELEASE_EN
    assign bus.evt_data  = fifo_rdata;
`else
    assign bus.evt_data  = fifo_rdata & 3'b011;
`endif
    assign key_held = held_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Scoreboard bench for ps2_key_event_ctrl; expected events follow the KEY_EVT_RELEASE_EN build choice.
module tb_ps2_key_event_ctrl;
    localparam int TMO = 16;
`ifdef KEY_EVT_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_held;
    logic       overflow;
    logic       clr_overflow;
    logic [2:0] sb [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    ps2_key_event_ctrl_if bus ();

    ps2_key_event_ctrl #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (rst),
        .bus          (bus),
        .key_held     (key_held),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // caller is always at a falling edge; the strobe is sampled at the next rising edge
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data   = b;
        bus.rx_strobe = 1'b1;
        @(negedge clk);
        bus.rx_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_press(input logic [1:0] k);
        sb.push_back({1'b0, k});
    endtask

    task automatic expect_release(input logic [1:0] k);
        if (REL) sb.push_back({1'b1, k});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        idle(2);
        check_eq({tag, "_sb_drained"}, sb.size(), 0);
        check_eq({tag, "_valid_idle"}, bus.evt_valid, 0);
    endtask

    initial begin : monitor
        logic [2:0] exp;
        forever begin
            @(negedge clk);
            #1;
            if (bus.evt_valid && bus.evt_ready) begin
                check_eq("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check_eq("evt_data", bus.evt_data, exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst           = 1'b1;
        clr_overflow  = 1'b0;
        bus.rx_data   = '0;
        bus.rx_strobe = 1'b0;
        bus.evt_ready = 1'b1;
        idle(3);
        check_eq("rst_valid", bus.evt_valid, 0);
        check_eq("rst_data", bus.evt_data, 0);
        check_eq("rst_held", key_held, 0);
        check_eq("rst_ovf", overflow, 0);
        rst = 1'b0;
        idle(1);

        // press then break of space; valid rises in the cycle after the sampling edge
        expect_press(2'd0);
        send_byte(8'h29);
        check_eq("t1_valid_latency", bus.evt_valid, 1);
        check_eq("t1_held_press", key_held, 4'b0001);
        expect_release(2'd0);
        send_byte(8'hF0);
        send_byte(8'h29);
        check_eq("t1_held_release", key_held, 4'b0000);
        drain("t1");

        // typematic repeats of enter yield a single press
        expect_press(2'd1);
        send_byte(8'h5A);
        send_byte(8'h5A);
        send_byte(8'h5A);
        check_eq("t2_held", key_held, 4'b0010);
        drain("t2");
        expect_release(2'd1);
        send_byte(8'hF0);
        send_byte(8'h5A);
        check_eq("t2_held_clr", key_held, 4'b0000);
        drain("t2b");

        // stalled consumer: four presses fill the FIFO, the release overflows
        bus.evt_ready = 1'b0;
        expect_press(2'd2); send_byte(8'h16);
        expect_press(2'd3); send_byte(8'h1E);
        expect_press(2'd0); send_byte(8'h29);
        expect_press(2'd1); send_byte(8'h5A);
        send_byte(8'hF0);
        send_byte(8'h16);
        check_eq("t3_held", key_held, 4'b1011);
        check_eq("t3_ovf", overflow, REL);
        check_eq("t3_head_stable", bus.evt_data, 3'b010);
        clr_overflow = 1'b1;
        idle(1);
        clr_overflow = 1'b0;
        check_eq("t3_ovf_clr", overflow, 0);
        // a drop coincident with clear leaves overflow set
        clr_overflow = 1'b1;
        send_byte(8'hF0);
        send_byte(8'h1E);
        clr_overflow = 1'b0;
        check_eq("t3_ovf_drop_wins", overflow, REL);
        check_eq("t3_held2", key_held, 4'b0011);
        clr_overflow = 1'b1;
        idle(1);
        clr_overflow = 1'b0;
        bus.evt_ready = 1'b1;
        drain("t3");
        expect_release(2'd0); send_byte(8'hF0); send_byte(8'h29);
        expect_release(2'd1); send_byte(8'hF0); send_byte(8'h5A);
        check_eq("t3_held_clr", key_held, 4'b0000);
        drain("t3b");

        // timeout boundary: TMO-1 idle cycles keeps the break prefix, TMO abandons it
        expect_press(2'd3);
        send_byte(8'h1E);
        send_byte(8'hF0);
        idle(TMO - 1);
        expect_release(2'd3);
        send_byte(8'h1E);
        check_eq("t4_held_brk_kept", key_held, 4'b0000);
        send_byte(8'hF0);
        idle(TMO);
        expect_press(2'd3);
        send_byte(8'h1E);
        check_eq("t4_held_timeout", key_held, 4'b1000);
        drain("t4");
        expect_release(2'd3); send_byte(8'hF0); send_byte(8'h1E);
        drain("t4b");

        // extended sequences are consumed silently and return to IDLE
        expect_press(2'd0);
        send_byte(8'h29);
        send_byte(8'hE0); send_byte(8'h5A);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h5A);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h29);
        check_eq("t5_held_ext", key_held, 4'b0001);
        expect_press(2'd1);
        send_byte(8'h5A);
        check_eq("t5_held_idle", key_held, 4'b0011);
        drain("t5");
        expect_release(2'd0); send_byte(8'hF0); send_byte(8'h29);
        expect_release(2'd1); send_byte(8'hF0); send_byte(8'h5A);
        drain("t5b");

        // reset after a dangling break prefix
        expect_press(2'd0);
        send_byte(8'h29);
        drain("t6a");
        send_byte(8'hF0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check_eq("t6_rst_held", key_held, 0);
        check_eq("t6_rst_valid", bus.evt_valid, 0);
        expect_press(2'd0);
        send_byte(8'h29);
        check_eq("t6_held", key_held, 4'b0001);
        drain("t6");
        expect_release(2'd0);
        send_byte(8'hF0);
        send_byte(8'h29);
        check_eq("t6_held_clr", key_held, 4'b0000);
        drain("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
